sipo_deser: RTL
===============

// Module: sipo_deser
// PURPOSE
// - Serial-in/parallel-out deserializer: receive end of the team's 4-bit LSB-first serial link (pairs with the PISO shifter).
// - Collects WIDTH qualified serial bits into a word and presents it on a one-entry valid/ready output buffer.
// - Flags overrun when a word completes while the buffer is still held.
// - Sits between the serial pin/sync logic and the parallel consumer.
// PARAMETERS
// - WIDTH      4   data bits per word (>=2)
// - LSB_FIRST  1   1: first received bit lands in po[0]; 0: first bit lands in po[WIDTH-1]
// PORTS
// - clk         in   1        clock, rising edge
// - reset       in   1        asynchronous, active-high
// - si          in   1        serial data bit
// - si_valid    in   1        si sampled on this edge when high
// - sync        in   1        word alignment; see BEHAVIOUR
// - po          out  WIDTH    assembled word (valid while po_valid)
// - po_valid    out  1        output buffer holds a word
// - po_ready    in   1        consumer accepts po when po_valid && po_ready
// - bit_cnt     out  CNT_W    bits of current partial word, 0..WIDTH-1
// - overrun     out  1        sticky: a completed word was dropped
// - ovr_clr     in   1        synchronous clear of overrun
// - parity_err  out  1        parity mismatch for word in buffer (SIPO_PARITY_EN only; else const 0)
// BEHAVIOUR
// - Reset (async): shift reg=0, bit_cnt=0, po=0, po_valid=0, overrun=0, parity_err=0, FSM=IDLE.
// - FSM: IDLE (bit_cnt==0) -> SHIFT on first si_valid; SHIFT -> IDLE on WIDTH-th bit.
// - With SIPO_PARITY_EN: SHIFT -> PAR on WIDTH-th bit; PAR -> IDLE on next si_valid.
// - Shift, LSB_FIRST=1: sreg <= {si, sreg[WIDTH-1:1]}. LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], si}.
// - Completion edge = WIDTH-th qualified bit (parity bit when enabled); the word moves to the buffer on that edge.
// - Latency: po_valid high in the cycle after the completion edge; no bubble between back-to-back words.
// - Buffer: po_valid clears on po_valid && po_ready unless a new word completes on the same edge.
// - Same-edge completion and accept: new word loads, po_valid stays 1.
// - Completion while po_valid && !po_ready: new word dropped, old word kept intact, overrun <= 1.
// - overrun: clears on ovr_clr. Set wins over a same-cycle ovr_clr.
// - sync && si_valid: partial word discarded; this bit is bit 0 (bit_cnt <= 1, FSM=SHIFT).
// - sync && !si_valid: partial word discarded, bit_cnt <= 0, FSM=IDLE. Buffer never affected by sync.
// - Reset mid-word or mid-buffer: everything returns to reset values immediately; the partial word is lost.
// CONFIGURATION
// - Macro SIPO_PARITY_EN defined:
//   - one extra even-parity bit follows the WIDTH data bits.
//   - Completion edge is the parity bit.
//   - parity_err = ^{data,parity} is loaded alongside po; the word is still delivered.
// - SIPO_PARITY_EN undefined: no PAR state; parity_err tied 0; bit_cnt range 0..WIDTH-1.
// STRUCTURE
// - Package sipo_pkg:
//   - state enum {IDLE, SHIFT, PAR}
//   - function cnt_w(WIDTH) = $clog2(WIDTH+1), used for CNT_W
//   - localparam PAR_EN derived from the macro
// - Sub-module sipo_out_buf: one-entry valid/ready holding register.
//   - Inputs: load, data, perr.
//   - Outputs: po, po_valid, parity_err.
//   - Generates the drop/overrun condition.
// - Top holds the FSM, the bit counter and the shift register.
// TESTING
// - Reset, then si=1,0,1,1 (LSB_FIRST=1) with si_valid=1, po_ready=1 -> po=4'b1101, po_valid high one cycle after the 4th bit.
// - Two words back-to-back, po_ready=1 -> po_valid stays high; po=word1, then word2 on the next cycle; overrun=0.
// - po_ready=0, send 2 words -> po holds word1, overrun=1 after 2nd completion; ovr_clr -> overrun=0.
// - 2 bits sent, then sync with si_valid=0, then 4 bits 0,0,1,0 -> po=4'b0100; the partial bits are discarded.
// - Assert reset after 3 bits; release; send 4'hA -> po=4'hA, bit_cnt=0 after completion.
// - SIPO_PARITY_EN: data 4'b0111 + parity 1 -> parity_err=0; same data + parity 0 -> parity_err=1, po=4'b0111.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the sipo_deser serial-to-parallel receiver.
// Optional feature: define SIPO_PARITY_EN to expect one even-parity bit after each word.
package sipo_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;

   // Bit-counter width; one spare code so the parity slot (count == width) fits.
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

`ifdef SIPO_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input, parallel valid/ready output and status bundle for sipo_deser.
interface sipo_deser_if #(
   parameter int unsigned WIDTH = 4
);
   import sipo_pkg::*;

   localparam int unsigned CNT_W = cnt_w(WIDTH);

   logic             si;
   logic             si_valid;
   logic             sync;
   logic [WIDTH-1:0] po;
   logic             po_valid;
   logic             po_ready;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;
   logic             ovr_clr;
   logic             parity_err;

   // Link/consumer side: drives serial bits and the output handshake.
   modport master (
      output si, si_valid, sync, po_ready, ovr_clr,
      input  po, po_valid, bit_cnt, overrun, parity_err
   );

   // Deserializer side.
   modport slave (
      input  si, si_valid, sync, po_ready, ovr_clr,
      output po, po_valid, bit_cnt, overrun, parity_err
   );

endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words, with sticky overrun.
// With SIPO_PARITY_EN the parity flag travels with the word; otherwise parity_err is 0.
module sipo_out_buf #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             perr,
   input  logic             po_ready,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   output logic             parity_err,
   output logic             overrun
);

   logic [WIDTH-1:0] po_q, po_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             drop;
   logic             take;

   // A held word that is not being accepted this edge wins over the new one.
   assign drop = load && valid_q && !po_ready;
   assign take = load && !drop;

   // Buffer next state: load beats accept, so back-to-back words leave no bubble.
   always_comb begin
      po_d    = po_q;
      valid_d = valid_q;
      ovr_d   = drop || (ovr_q && !ovr_clr);
      if (take) begin
         po_d    = data;
         valid_d = 1'b1;
      end else if (valid_q && po_ready) begin
         valid_d = 1'b0;
      end
   end

   // Buffer and overrun registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         po_q    <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         po_q    <= po_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef SIPO_PARITY_EN
   logic perr_q;

   // Parity flag is captured with the word it describes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else if (take) begin
         perr_q <= perr;
      end
   end

   assign parity_err = perr_q;
`else
   logic unused_perr;
   assign unused_perr = perr;
   assign parity_err  = 1'b0;
`endif

   assign po       = po_q;
   assign po_valid = valid_q;
   assign overrun  = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles WIDTH qualified bits into a word and
// hands it to a one-entry output buffer. Define SIPO_PARITY_EN for a trailing parity bit.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          LSB_FIRST = 1'b1
) (
   input logic         clk,
   input logic         reset,
   sipo_deser_if.slave bus
);

   localparam int unsigned CNT_W = cnt_w(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             load_perr;

   // Shift-register value if the current serial bit is taken.
   always_comb begin
      if (LSB_FIRST) begin
         sreg_shift = {bus.si, sreg_q[WIDTH-1:1]};
      end else begin
         sreg_shift = {sreg_q[WIDTH-2:0], bus.si};
      end
   end

   // Word-assembly FSM; sync realigns and takes priority over completion.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      load      = 1'b0;
      load_data = sreg_shift;
      load_perr = 1'b0;
      if (bus.sync) begin
         if (bus.si_valid) begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(1);
            sreg_d  = sreg_shift;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else if (bus.si_valid) begin
         unique case (state_q)
            IDLE, SHIFT: begin
               sreg_d = sreg_shift;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  // Last data bit: either the word is done or the parity slot follows.
                  state_d = PAR_EN ? PAR : IDLE;
                  cnt_d   = PAR_EN ? CNT_W'(WIDTH) : '0;
                  load    = !PAR_EN;
               end else begin
                  state_d = SHIFT;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            PAR: begin
               load      = 1'b1;
               load_data = sreg_q;
               load_perr = ^{sreg_q, bus.si};
               state_d   = IDLE;
               cnt_d     = '0;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM, bit counter and shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
      end
   end

   assign bus.bit_cnt = cnt_q;

   sipo_out_buf #(
      .WIDTH (WIDTH)
   ) u_out_buf (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .data       (load_data),
      .perr       (load_perr),
      .po_ready   (bus.po_ready),
      .ovr_clr    (bus.ovr_clr),
      .po         (bus.po),
      .po_valid   (bus.po_valid),
      .parity_err (bus.parity_err),
      .overrun    (bus.overrun)
   );

endmodule
